lc4_dport_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the LC4 memory data port: daddr/din/dwe/dre and dout. It shares the single data port between the core's load/store unit (m0) and a secondary master (m1: loader/DMA/debug). It issues at most one access per enabled cycle and returns read data to the correct requester after a fixed memory latency. It supports locked bursts with a bounded hold time.

---
 rtl/lc4_mem_pkg.sv | 22 ++
 rtl/lc4_rd_tag_pipe.sv | 36 +++
 rtl/lc4_dport_arbiter.sv | 157 +++++++++++++++
 tb/tb_lc4_dport_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lc4_mem_pkg.sv
// Shared types and limits for the LC4 data-port arbiter and its read-tag pipeline.
package lc4_mem_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        M0   = 2'd1,
        M1   = 2'd2
    } owner_e;

    localparam int ID_W         = 1;
    localparam int READ_LAT_MAX = 8;
    localparam int BURST_CNT_W  = 4;

    // Burst counter increment that sticks at the configured limit.
    function automatic logic [BURST_CNT_W-1:0] sat_inc(
        input logic [BURST_CNT_W-1:0] cnt,
        input logic [BURST_CNT_W-1:0] lim
    );
        return (cnt >= lim) ? lim : cnt + BURST_CNT_W'(1);
    endfunction

endpackage

// File: rtl/lc4_rd_tag_pipe.sv
// Fixed-depth {valid, id} shift register tracking outstanding loads; shifts only when enabled.
module lc4_rd_tag_pipe
    import lc4_mem_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            push_vld,
    input  logic [ID_W-1:0] push_id,
    output logic            tail_vld,
    output logic [ID_W-1:0] tail_id
);

    logic [DEPTH-1:0]           vld_q;
    logic [DEPTH-1:0][ID_W-1:0] id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            id_q  <= '0;
        end else if (en) begin
            vld_q[0] <= push_vld;
            id_q[0]  <= push_id;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                id_q[i]  <= id_q[i-1];
            end
        end
    end

    assign tail_vld = vld_q[DEPTH-1];
    assign tail_id  = id_q[DEPTH-1];

endmodule

// File: rtl/lc4_dport_arbiter.sv
// Two-master arbiter for the LC4 data port: round-robin ties, locked bursts with bounded hold,
// and read-data steering after a fixed memory latency.
//
// state | meaning
// NONE  | no owner; arbitrate single request or round-robin tie
// M0    | m0 holds a locked burst; m0 keeps winning until it drops or hits MAX_BURST with m1 waiting
// M1    | m1 holds a locked burst; symmetric to M0
module lc4_dport_arbiter
    import lc4_mem_pkg::*;
#(
    parameter int READ_LAT  = 1,
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gwe,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic        m0_lock,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m0_wdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic        m1_lock,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_rvalid,
    output logic        m1_rvalid,
    output logic [15:0] m0_rdata,
    output logic [15:0] m1_rdata,
    output logic        mem_dre,
    output logic        mem_dwe,
    output logic [15:0] mem_daddr,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout
);

    localparam logic [BURST_CNT_W-1:0] MAX_CNT = BURST_CNT_W'(MAX_BURST);
    localparam logic [BURST_CNT_W-1:0] CNT_ONE = BURST_CNT_W'(1);

    owner_e                 owner, owner_nxt;
    logic [BURST_CNT_W-1:0] burst_cnt, burst_nxt;
    logic [ID_W-1:0]        rr_last, rr_nxt;

    logic                   gnt0, gnt1;
    logic                   tie0, tie1;
    logic [BURST_CNT_W-1:0] cnt_inc;

    logic                   tail_vld;
    logic [ID_W-1:0]        tail_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= NONE;
            burst_cnt <= '0;
            rr_last   <= 1'b1;
        end else begin
            owner     <= owner_nxt;
            burst_cnt <= burst_nxt;
            rr_last   <= rr_nxt;
        end
    end

    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        owner_nxt = owner;
        burst_nxt = burst_cnt;
        rr_nxt    = rr_last;
        cnt_inc   = CNT_ONE;
        tie0      = m0_req && (!m1_req || (rr_last == 1'b1));
        tie1      = m1_req && (!m0_req || (rr_last == 1'b0));

        // Grants are suppressed during reset so every enable reads 0 while rst_n is low.
        if (gwe && rst_n) begin
            unique case (owner)
                M0: begin
                    if (m0_req) begin
                        if (m1_req && (burst_cnt == MAX_CNT)) gnt1 = 1'b1;
                        else                                  gnt0 = 1'b1;
                    end else begin
                        gnt0 = tie0;
                        gnt1 = tie1;
                    end
                end
                M1: begin
                    if (m1_req) begin
                        if (m0_req && (burst_cnt == MAX_CNT)) gnt0 = 1'b1;
                        else                                  gnt1 = 1'b1;
                    end else begin
                        gnt0 = tie0;
                        gnt1 = tie1;
                    end
                end
                default: begin
                    gnt0 = tie0;
                    gnt1 = tie1;
                end
            endcase

            if ((owner == M0 && !m0_req) || (owner == M1 && !m1_req)) begin
                owner_nxt = NONE;
                burst_nxt = '0;
            end

            // A lock that would reach MAX_BURST while the other master waits is not honoured.
            if (gnt0) begin
                rr_nxt  = 1'b0;
                cnt_inc = (owner == M0) ? sat_inc(burst_cnt, MAX_CNT) : CNT_ONE;
                if (m0_lock && !(m1_req && (cnt_inc == MAX_CNT))) begin
                    owner_nxt = M0;
                    burst_nxt = cnt_inc;
                end else begin
                    owner_nxt = NONE;
                    burst_nxt = '0;
                end
            end else if (gnt1) begin
                rr_nxt  = 1'b1;
                cnt_inc = (owner == M1) ? sat_inc(burst_cnt, MAX_CNT) : CNT_ONE;
                if (m1_lock && !(m0_req && (cnt_inc == MAX_CNT))) begin
                    owner_nxt = M1;
                    burst_nxt = cnt_inc;
                end else begin
                    owner_nxt = NONE;
                    burst_nxt = '0;
                end
            end
        end
    end

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign mem_daddr = gnt1 ? m1_addr  : m0_addr;
    assign mem_din   = gnt1 ? m1_wdata : m0_wdata;
    assign mem_dwe   = (gnt0 && m0_we)  || (gnt1 && m1_we);
    assign mem_dre   = (gnt0 && !m0_we) || (gnt1 && !m1_we);

    lc4_rd_tag_pipe #(
        .DEPTH (READ_LAT)
    ) u_rd_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (gwe),
        .push_vld (mem_dre),
        .push_id  (gnt1),
        .tail_vld (tail_vld),
        .tail_id  (tail_id)
    );

    assign m0_rvalid = gwe && tail_vld && (tail_id == 1'b0);
    assign m1_rvalid = gwe && tail_vld && (tail_id == 1'b1);
    assign m0_rdata  = mem_dout;
    assign m1_rdata  = mem_dout;

endmodule

// File: tb/tb_lc4_dport_arbiter.sv
// Directed bench: two arbiters (READ_LAT 1 and 3) share stimulus; a small memory model feeds each.
module tb_lc4_dport_arbiter;

    logic        clk = 1'b0;
    logic        rst_n, gwe;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic        a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_mem_dre, a_mem_dwe;
    logic [15:0] a_m0_rdata, a_m1_rdata, a_mem_daddr, a_mem_din, a_dout;
    logic        b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_mem_dre, b_mem_dwe;
    logic [15:0] b_m0_rdata, b_m1_rdata, b_mem_daddr, b_mem_din, b_dout;

    logic [15:0] mem [0:1023];
    logic [15:0] rq1;
    logic [15:0] rq3 [0:2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lc4_dport_arbiter #(.READ_LAT(1), .MAX_BURST(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .gwe(gwe),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(a_m0_gnt), .m1_gnt(a_m1_gnt), .m0_rvalid(a_m0_rvalid), .m1_rvalid(a_m1_rvalid),
        .m0_rdata(a_m0_rdata), .m1_rdata(a_m1_rdata), .mem_dre(a_mem_dre), .mem_dwe(a_mem_dwe),
        .mem_daddr(a_mem_daddr), .mem_din(a_mem_din), .mem_dout(a_dout)
    );

    lc4_dport_arbiter #(.READ_LAT(3), .MAX_BURST(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .gwe(gwe),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(b_m0_gnt), .m1_gnt(b_m1_gnt), .m0_rvalid(b_m0_rvalid), .m1_rvalid(b_m1_rvalid),
        .m0_rdata(b_m0_rdata), .m1_rdata(b_m1_rdata), .mem_dre(b_mem_dre), .mem_dwe(b_mem_dwe),
        .mem_daddr(b_mem_daddr), .mem_din(b_mem_din), .mem_dout(b_dout)
    );

    // Memory: writes from the latency-1 instance; each instance gets its own address delay line.
    always @(posedge clk) begin
        if (gwe && a_mem_dwe) mem[a_mem_daddr[9:0]] <= a_mem_din;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq1    <= '0;
            rq3[0] <= '0;
            rq3[1] <= '0;
            rq3[2] <= '0;
        end else if (gwe) begin
            rq1    <= a_mem_daddr;
            rq3[0] <= b_mem_daddr;
            rq3[1] <= rq3[0];
            rq3[2] <= rq3[1];
        end
    end

    assign a_dout = mem[rq1[9:0]];
    assign b_dout = mem[rq3[2][9:0]];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[10'h010] = 16'hBEEF;
        mem[10'h100] = 16'hA000;
        mem[10'h101] = 16'hA001;
        mem[10'h102] = 16'hA002;
        mem[10'h103] = 16'hA003;

        rst_n = 1'b0; gwe = 1'b1;
        m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 16'h0; m0_wdata = 16'h0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 16'h0; m1_wdata = 16'h0;

        // Reset state
        @(negedge clk);
        chk("rst_m0_gnt",    16'(a_m0_gnt),    16'h0);
        chk("rst_m1_gnt",    16'(a_m1_gnt),    16'h0);
        chk("rst_dre",       16'(a_mem_dre),   16'h0);
        chk("rst_dwe",       16'(a_mem_dwe),   16'h0);
        chk("rst_m0_rvalid", 16'(a_m0_rvalid), 16'h0);
        chk("rst_rdata",     a_m0_rdata,       a_dout);
        tick();
        rst_n = 1'b1;

        // Single m0 load, latency 1
        m0_req = 1; m0_we = 0; m0_addr = 16'h0010;
        @(negedge clk);
        chk("ld_m0_gnt", 16'(a_m0_gnt),  16'h1);
        chk("ld_m1_gnt", 16'(a_m1_gnt),  16'h0);
        chk("ld_dre",    16'(a_mem_dre), 16'h1);
        chk("ld_daddr",  a_mem_daddr,    16'h0010);
        tick();
        m0_req = 0;
        @(negedge clk);
        chk("ld_m0_rvalid", 16'(a_m0_rvalid), 16'h1);
        chk("ld_m0_rdata",  a_m0_rdata,       16'hBEEF);
        chk("ld_m1_rvalid", 16'(a_m1_rvalid), 16'h0);
        chk("ld_gnt_idle",  16'(a_m0_gnt),    16'h0);
        tick();

        // Round-robin: last grant was m0, so m1 wins first
        m0_req = 1; m0_addr = 16'h0020;
        m1_req = 1; m1_we = 0; m1_addr = 16'h0030;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_m1_gnt", 16'(a_m1_gnt), (i % 2 == 0) ? 16'h1 : 16'h0);
            chk("rr_m0_gnt", 16'(a_m0_gnt), (i % 2 == 1) ? 16'h1 : 16'h0);
            chk("rr_daddr",  a_mem_daddr,   (i % 2 == 0) ? 16'h0030 : 16'h0020);
            tick();
        end

        // Locked burst by m1, bounded at 4 grants; m0 then keeps a locked burst
        m0_lock = 1; m0_we = 1; m0_addr = 16'h0050; m0_wdata = 16'h5555;
        m1_lock = 1; m1_we = 1; m1_addr = 16'h0040; m1_wdata = 16'h4444;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bst_m1_gnt", 16'(a_m1_gnt), (i < 4) ? 16'h1 : 16'h0);
            chk("bst_m0_gnt", 16'(a_m0_gnt), (i >= 4) ? 16'h1 : 16'h0);
            tick();
        end
        // Owner drops its request: m1 is granted in the same cycle
        m0_req = 0; m0_lock = 0; m1_lock = 0;
        @(negedge clk);
        chk("rel_m1_gnt", 16'(a_m1_gnt), 16'h1);
        chk("rel_m0_gnt", 16'(a_m0_gnt), 16'h0);
        tick();
        m1_req = 0; m1_we = 0; m0_we = 0;
        for (int i = 0; i < 4; i++) tick();

        // Latency 3 with a two-cycle freeze mid-stream
        m0_req = 1; m0_addr = 16'h0100;
        @(negedge clk);
        chk("fz_gnt_t0", 16'(b_m0_gnt), 16'h1);
        tick();
        m0_addr = 16'h0101;
        @(negedge clk);
        chk("fz_gnt_t1", 16'(b_m0_gnt), 16'h1);
        tick();
        gwe = 0; m0_addr = 16'h0102;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("fz_gnt_off",   16'(b_m0_gnt),    16'h0);
            chk("fz_dre_off",   16'(b_mem_dre),   16'h0);
            chk("fz_rv_off",    16'(b_m0_rvalid), 16'h0);
            chk("fz_a_rv_off",  16'(a_m0_rvalid), 16'h0);
            tick();
        end
        gwe = 1;
        @(negedge clk);
        chk("fz_gnt_t4",    16'(b_m0_gnt),    16'h1);
        chk("fz_rv_t4",     16'(b_m0_rvalid), 16'h0);
        chk("fz_a_rv_t4",   16'(a_m0_rvalid), 16'h1);
        chk("fz_a_data_t4", a_m0_rdata,       16'hA001);
        tick();
        m0_addr = 16'h0103;
        @(negedge clk);
        chk("fz_gnt_t5",  16'(b_m0_gnt),    16'h1);
        chk("fz_rv_t5",   16'(b_m0_rvalid), 16'h1);
        chk("fz_data_t5", b_m0_rdata,       16'hA000);
        tick();
        m0_req = 0;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("fz_rv_tail",   16'(b_m0_rvalid), 16'h1);
            chk("fz_data_tail", b_m0_rdata,       16'hA000 + 16'(i));
            chk("fz_m1_rv",     16'(b_m1_rvalid), 16'h0);
            tick();
        end
        @(negedge clk);
        chk("fz_rv_done", 16'(b_m0_rvalid), 16'h0);
        tick();

        // Reset while a load is in flight
        m0_req = 1; m0_we = 0; m0_addr = 16'h0010;
        @(negedge clk);
        chk("rl_gnt", 16'(b_m0_gnt), 16'h1);
        tick();
        rst_n = 0;
        m0_req = 1; m0_we = 1; m0_addr = 16'h03F0;
        m1_req = 1; m1_we = 1; m1_addr = 16'h03F1;
        @(negedge clk);
        chk("rl_m0_gnt", 16'(a_m0_gnt),    16'h0);
        chk("rl_m1_gnt", 16'(a_m1_gnt),    16'h0);
        chk("rl_dre",    16'(a_mem_dre),   16'h0);
        chk("rl_dwe",    16'(a_mem_dwe),   16'h0);
        chk("rl_a_rv",   16'(a_m0_rvalid), 16'h0);
        chk("rl_b_rv",   16'(b_m0_rvalid), 16'h0);
        tick();
        rst_n = 1;
        @(negedge clk);
        chk("rl_tie_m0", 16'(a_m0_gnt),    16'h1);
        chk("rl_tie_m1", 16'(a_m1_gnt),    16'h0);
        chk("rl_b_rv2",  16'(b_m0_rvalid), 16'h0);
        tick();
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rl_b_never", 16'(b_m0_rvalid), 16'h0);
            chk("rl_a_never", 16'(a_m0_rvalid), 16'h0);
            tick();
        end

        // Store by m0, then load of same address by m1
        m0_req = 1; m0_we = 1; m0_addr = 16'h0200; m0_wdata = 16'h1234;
        @(negedge clk);
        chk("st_gnt",   16'(a_m0_gnt),  16'h1);
        chk("st_dwe",   16'(a_mem_dwe), 16'h1);
        chk("st_dre",   16'(a_mem_dre), 16'h0);
        chk("st_din",   a_mem_din,      16'h1234);
        chk("st_daddr", a_mem_daddr,    16'h0200);
        tick();
        m0_req = 0; m0_we = 0;
        m1_req = 1; m1_we = 0; m1_addr = 16'h0200;
        @(negedge clk);
        chk("ld1_gnt", 16'(a_m1_gnt),  16'h1);
        chk("ld1_dwe", 16'(a_mem_dwe), 16'h0);
        chk("ld1_dre", 16'(a_mem_dre), 16'h1);
        tick();
        m1_req = 0;
        @(negedge clk);
        chk("ld1_rvalid",    16'(a_m1_rvalid), 16'h1);
        chk("ld1_rdata",     a_m1_rdata,       16'h1234);
        chk("ld1_m0_rvalid", 16'(a_m0_rvalid), 16'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
